// File: rtl/kcounter_filter.sv
// kcounter_filter: signed random-walk (K-counter) loop filter for a digital PLL.
// The phase detector's increment/decrement pulses move a WIDTH-bit signed counter.
// When the counter reaches +K it emits a one-cycle carry pulse. When it reaches -K
// it emits a one-cycle borrow pulse. After either pulse the counter reloads.
// The lock detector is optional. Define KCOUNTER_LOCK_DETECT_EN to build it.
// When that macro is undefined, lock_o is tied to 0.
module kcounter_filter #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    increment_i,
  input  logic                    decrement_i,
  input  logic        [WIDTH-2:0] k_i,
  input  logic signed [WIDTH-1:0] initial_i,
  output logic                    carry_o,
  output logic                    borrow_o,
  output logic signed [WIDTH-1:0] value_o,
  output logic                    lock_o
);

  // All threshold arithmetic uses one extra bit, so value +/- 1 can never wrap.
  logic signed [WIDTH:0]   keff;
  logic signed [WIDTH:0]   step;
  logic signed [WIDTH:0]   nxt;
  logic signed [WIDTH:0]   init_x;
  logic signed [WIDTH-1:0] reload;
  logic                    hit_hi;
  logic                    hit_lo;

  // Effective modulus, step, threshold tests and reload selection.
  always_comb begin
    keff   = (k_i == '0) ? (WIDTH+1)'(1) : {2'b00, k_i};
    step   = '0;
    if (increment_i && !decrement_i) step = (WIDTH+1)'(1);
    if (decrement_i && !increment_i) step = -(WIDTH+1)'(1);
    nxt    = {value_o[WIDTH-1], value_o} + step;
    init_x = {initial_i[WIDTH-1], initial_i};
    // Keff >= 1, so hit_hi and hit_lo are mutually exclusive.
    hit_hi = (nxt >= keff);
    hit_lo = (nxt <= -keff);
    // An out-of-window reload would retrigger immediately, so fall back to 0.
    reload = ((init_x > -keff) && (init_x < keff)) ? initial_i : '0;
  end

  // Counter and trigger pulse registers.
  // When the enable is low, the counter holds and both pulses are cleared.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      value_o  <= '0;
      carry_o  <= 1'b0;
      borrow_o <= 1'b0;
    end else if (en_i) begin
      carry_o  <= hit_hi;
      borrow_o <= hit_lo;
      value_o  <= (hit_hi || hit_lo) ? reload : nxt[WIDTH-1:0];
    end else begin
      carry_o  <= 1'b0;
      borrow_o <= 1'b0;
    end
  end

`ifdef KCOUNTER_LOCK_DETECT_EN
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;

  // Quiet-loop timer.
  // A trigger clears it. Each other enabled edge advances it, saturating at LOCK_CYCLES.
  always_comb begin
    timer_d = timer;
    if (en_i) begin
      if (hit_hi || hit_lo) timer_d = '0;
      else if (timer != TW'(LOCK_CYCLES)) timer_d = timer + TW'(1);
    end
  end

  // Timer and lock registers.
  // Lock is computed from the next timer value, so it drops in the same cycle as the pulse.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      timer  <= '0;
      lock_o <= 1'b0;
    end else begin
      timer  <= timer_d;
      lock_o <= (timer_d == TW'(LOCK_CYCLES));
    end
  end
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_kcounter_filter.sv
// tb_kcounter_filter: directed and randomized bench for kcounter_filter.
// The bench keeps an integer reference model of the filter's rules.
// Expected outputs are pushed onto a queue and compared against the DUT after each edge.
module tb_kcounter_filter;
  localparam int WIDTH = 8;
  localparam int LC    = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic                    inc;
  logic                    dec;
  logic        [WIDTH-2:0] k;
  logic signed [WIDTH-1:0] init;
  logic                    carry;
  logic                    borrow;
  logic                    lock;
  logic signed [WIDTH-1:0] value;

  kcounter_filter #(.WIDTH(WIDTH), .LOCK_CYCLES(LC)) dut (
    .clk_i(clk), .reset_i(rst_n), .en_i(en), .increment_i(inc),
    .decrement_i(dec), .k_i(k), .initial_i(init), .carry_o(carry),
    .borrow_o(borrow), .value_o(value), .lock_o(lock)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, held as plain integers
  int m_val   = 0;
  int m_quiet = 0;
  bit m_c     = 1'b0;
  bit m_b     = 1'b0;

  // Scoreboard entry layout: {lock, borrow, carry, value}
  logic [WIDTH+2:0] exp_q[$];

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one edge of the filter's rules to the model.
  task automatic model(input bit r, input bit e, input bit i, input bit d,
                       input int kk, input int ii);
    int keff, rl, n;
    if (!r) begin
      m_val = 0; m_c = 0; m_b = 0; m_quiet = 0;
    end else if (e) begin
      keff = (kk == 0) ? 1 : kk;
      rl   = (ii > -keff && ii < keff) ? ii : 0;
      n    = m_val + int'(i) - int'(d);
      m_c  = (n >= keff);
      m_b  = (n <= -keff);
      if (m_c || m_b) begin
        m_val = rl; m_quiet = 0;
      end else begin
        m_val = n;
        if (m_quiet < LC) m_quiet++;
      end
    end else begin
      m_c = 0; m_b = 0;
    end
  endtask

  // Driver: drive inputs at the falling edge, update the model at the rising
  // edge, then compare all outputs 1 time unit after that edge.
  task automatic cycle(input bit r, input bit e, input bit i, input bit d,
                       input int kk, input int ii);
    logic [WIDTH+2:0] x;
    logic [WIDTH-1:0] ev;
    bit               el;
    @(negedge clk);
    rst_n = r; en = e; inc = i; dec = d;
    k = kk[WIDTH-2:0]; init = ii[WIDTH-1:0];
    @(posedge clk);
    model(r, e, i, d, kk, ii);
    ev = m_val[WIDTH-1:0];
`ifdef KCOUNTER_LOCK_DETECT_EN
    el = (m_quiet == LC);
`else
    el = 1'b0;
`endif
    exp_q.push_back({el, m_b, m_c, ev});
    #1;
    x = exp_q.pop_front();
    check("value",  value,  x[WIDTH-1:0]);
    check("carry",  {{(WIDTH-1){1'b0}}, carry},  {{(WIDTH-1){1'b0}}, x[WIDTH]});
    check("borrow", {{(WIDTH-1){1'b0}}, borrow}, {{(WIDTH-1){1'b0}}, x[WIDTH+1]});
    check("lock",   {{(WIDTH-1){1'b0}}, lock},   {{(WIDTH-1){1'b0}}, x[WIDTH+2]});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; inc = 1'b0; dec = 1'b0; k = '0; init = '0;

    // Reset held with increment high
    repeat (3) cycle(0, 1, 1, 0, 8, 0);
    check("rst_value", value, 8'd0);

    // K = 8, reload 0: steps 1..7, then a carry on the 8th edge
    repeat (8) cycle(1, 1, 1, 0, 8, 0);
    check("k8_carry_const", {7'd0, carry}, 8'd1);
    check("k8_value_const", value, 8'd0);

    // K = 5, reload 2, decrement held: borrow every 7 cycles
    repeat (16) cycle(1, 1, 0, 1, 5, 2);

    // Set the value to 3, then hold inc and dec together for 20 cycles
    cycle(0, 1, 0, 0, 8, 0);
    repeat (3) cycle(1, 1, 1, 0, 8, 0);
    repeat (20) cycle(1, 1, 1, 1, 8, 0);
    check("cancel_hold_const", value, 8'sd3);

    // Step the value to 6, then lower K to 4: one carry, then a reload
    repeat (3) cycle(1, 1, 1, 0, 8, 0);
    cycle(1, 1, 0, 0, 4, 1);
    check("klower_carry_const", {7'd0, carry}, 8'd1);
    check("klower_reload_const", value, 8'sd1);
    repeat (3) cycle(1, 1, 0, 0, 4, 1);

    // K = 0 acts as Keff = 1: carry on every edge
    repeat (5) cycle(1, 1, 1, 0, 0, 0);

    // A reload value outside the window falls back to 0
    repeat (10) cycle(1, 1, 1, 0, 8, 9);

    // Lock: quiet run, then a forced carry, then a timer pause while disabled
    repeat (20) cycle(1, 1, 0, 0, 8, 0);
    repeat (8) cycle(1, 1, 1, 0, 8, 0);
    repeat (6) cycle(1, 1, 0, 0, 8, 0);
    repeat (5) cycle(1, 0, 1, 0, 8, 0);
    repeat (14) cycle(1, 1, 0, 0, 8, 0);

    // Randomized stimulus
    begin
      int kk = 6;
      int ii = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 30) == 0)
          kk = ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, 10));
        if ($urandom_range(0, 15) == 0) ii = int'($urandom_range(0, 24)) - 12;
        cycle($urandom_range(0, 300) != 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, kk, ii);
      end
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
